// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encoding and request-type decode for data_mem_responder.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_RD_LAT = 2;

    // Wait counter holds RD_LAT-1, and RD_LAT never exceeds 15.
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_ERR = 2'd2
    } dmem_op_e;

    // Read and write asserted together is illegal and is tracked as its own type.
    function automatic dmem_op_e decode_op(input logic rd, input logic wr);
        if (rd && wr) return OP_ERR;
        if (wr)       return OP_WR;
        return OP_RD;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the pipeline MEM stage.
// Build option DMEM_POSTED_WR_EN: legal writes commit at accept and respond on the next cycle.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int RD_LAT = DMEM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(RD_LAT - 1);

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    dmem_op_e                op_q, op_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    arr_we;
    logic [ADDR_W-1:0]       arr_addr;
    logic [DATA_W-1:0]       arr_wdata;
    logic [DATA_W-1:0]       arr_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        arr_we      = 1'b0;
        arr_addr    = addr_q;
        arr_wdata   = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    op_d    = decode_op(req_rd, req_wr);
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
`ifdef DMEM_POSTED_WR_EN
                    // Posted write: commit straight from the request bus, skip WAIT.
                    if (op_d == OP_WR) begin
                        arr_we      = 1'b1;
                        arr_addr    = req_addr;
                        arr_wdata   = req_wdata;
                        cnt_d       = '0;
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    case (op_q)
                        OP_RD:   rsp_rdata_d = arr_rdata;
                        OP_WR:   arr_we      = 1'b1;
                        default: rsp_err_d   = 1'b1;
                    endcase
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset aborts any access in flight, including a pending write.
        if (rst) begin
            arr_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= OP_RD;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner-case sequences and random traffic vs a memory model.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_v    [2];
    logic        wr_v    [2];
    logic [11:0] addr_v  [2];
    logic [15:0] wdata_v [2];
    logic        ready_v [2];
    logic        valid_v [2];
    logic [15:0] rdata_v [2];
    logic        err_v   [2];
    logic        busy_v  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] model_mem [logic [11:0]];

    data_mem_responder #(.ADDR_W(12), .DATA_W(16), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_rd(rd_v[0]), .req_wr(wr_v[0]), .req_addr(addr_v[0]), .req_wdata(wdata_v[0]),
        .req_ready(ready_v[0]), .rsp_valid(valid_v[0]), .rsp_rdata(rdata_v[0]),
        .rsp_err(err_v[0]), .busy(busy_v[0])
    );

    data_mem_responder #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_rd(rd_v[1]), .req_wr(wr_v[1]), .req_addr(addr_v[1]), .req_wdata(wdata_v[1]),
        .req_ready(ready_v[1]), .rsp_valid(valid_v[1]), .rsp_rdata(rdata_v[1]),
        .rsp_err(err_v[1]), .busy(busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Edges from the accept edge until rsp_valid is seen after an edge.
    function automatic int exp_lat(input int s, input logic rd, input logic wr);
        int l;
        l = (s == 0) ? 2 : 1;
`ifdef DMEM_POSTED_WR_EN
        if (wr && !rd) l = 0;
`endif
        return l;
    endfunction

    task automatic txn(input int s, input logic rd, input logic wr, input logic [11:0] a,
                       input logic [15:0] d, output logic [15:0] rdata, output logic err,
                       output int lat);
        int n;
        int bad;
        rd_v[s] = rd; wr_v[s] = wr; addr_v[s] = a; wdata_v[s] = d;
        n = 0;
        while (!ready_v[s] && n < 50) begin
            tick();
            n++;
        end
        check("accept_in_time", 32'(n < 50), 1);
        tick();
        rd_v[s] = 1'b0; wr_v[s] = 1'b0; wdata_v[s] = 16'h0;
        lat = 0; bad = 0;
        while (!valid_v[s] && lat < 40) begin
            if (rdata_v[s] !== 16'h0 || err_v[s] !== 1'b0 || busy_v[s] !== 1'b1) bad++;
            tick();
            lat++;
        end
        check("rsp_in_time", 32'(lat < 40), 1);
        check("wait_quiet_busy", bad, 0);
        rdata = rdata_v[s];
        err   = err_v[s];
        check("resp_busy", busy_v[s], 1);
        tick();
        check("resp_one_cycle", valid_v[s], 0);
        check("idle_ready", ready_v[s], 1);
    endtask

    initial begin
        vec_t        vecs [10];
        logic [11:0] pool [8];
        logic [15:0] got_d;
        logic        got_e;
        int          lat;
        int          cnt;
        int          acc_edge [3];
        int          n_acc;
        int          rsp_edge;
        int          bad;

        vecs[0] = '{rd:1'b0, wr:1'b1, addr:12'h010, wdata:16'hBEEF, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[1] = '{rd:1'b1, wr:1'b0, addr:12'h010, wdata:16'h0000, exp_rdata:16'hBEEF, exp_err:1'b0};
        vecs[2] = '{rd:1'b0, wr:1'b1, addr:12'h005, wdata:16'h1234, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[3] = '{rd:1'b1, wr:1'b1, addr:12'h005, wdata:16'hDEAD, exp_rdata:16'h0000, exp_err:1'b1};
        vecs[4] = '{rd:1'b1, wr:1'b0, addr:12'h005, wdata:16'h0000, exp_rdata:16'h1234, exp_err:1'b0};
        vecs[5] = '{rd:1'b0, wr:1'b1, addr:12'hFFF, wdata:16'h0001, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[6] = '{rd:1'b1, wr:1'b0, addr:12'hFFF, wdata:16'h0000, exp_rdata:16'h0001, exp_err:1'b0};
        vecs[7] = '{rd:1'b0, wr:1'b1, addr:12'h000, wdata:16'h5A5A, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[8] = '{rd:1'b1, wr:1'b0, addr:12'h000, wdata:16'h0000, exp_rdata:16'h5A5A, exp_err:1'b0};
        vecs[9] = '{rd:1'b0, wr:1'b1, addr:12'h020, wdata:16'h0000, exp_rdata:16'h0000, exp_err:1'b0};
        pool = '{12'h010, 12'h005, 12'hFFF, 12'h000, 12'h020, 12'h3A7, 12'h800, 12'h0C1};

        for (int s = 0; s < 2; s++) begin
            rd_v[s] = 1'b0; wr_v[s] = 1'b0; addr_v[s] = 12'h0; wdata_v[s] = 16'h0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", ready_v[s], 1);
            check("reset_busy",  busy_v[s],  0);
            check("reset_valid", valid_v[s], 0);
            check("reset_rdata", rdata_v[s], 0);
            check("reset_err",   err_v[s],   0);
        end
        rst = 1'b0;
        tick();

        // Directed vectors, model kept in step with every write.
        for (int i = 0; i < 10; i++) begin
            txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got_d, got_e, lat);
            check($sformatf("vec%0d_rdata", i), got_d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), got_e, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, exp_lat(0, vecs[i].rd, vecs[i].wr));
            if (vecs[i].wr && !vecs[i].rd) model_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // Write request presented while reset is held must not land.
        rst = 1'b1;
        rd_v[0] = 1'b0; wr_v[0] = 1'b1; addr_v[0] = 12'h005; wdata_v[0] = 16'hFFFF;
        tick();
        check("rst_req_ready", ready_v[0], 1);
        check("rst_req_busy",  busy_v[0],  0);
        rst = 1'b0; wr_v[0] = 1'b0;
        tick();
        check("rst_req_not_taken", busy_v[0], 0);
        txn(0, 1'b1, 1'b0, 12'h005, 16'h0, got_d, got_e, lat);
        check("rst_req_mem_kept", got_d, 16'h1234);

        // Reset while the access is waiting.
`ifdef DMEM_POSTED_WR_EN
        rd_v[0] = 1'b1; wr_v[0] = 1'b0;
`else
        rd_v[0] = 1'b0; wr_v[0] = 1'b1;
`endif
        addr_v[0] = 12'h020; wdata_v[0] = 16'hAAAA;
        tick();
        rd_v[0] = 1'b0; wr_v[0] = 1'b0;
        check("midrst_in_wait", busy_v[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", valid_v[0], 0);
        check("midrst_ready", ready_v[0], 1);
        check("midrst_busy",  busy_v[0],  0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_v[0]) cnt++;
        end
        check("midrst_no_rsp", cnt, 0);
        txn(0, 1'b1, 1'b0, 12'h020, 16'h0, got_d, got_e, lat);
        check("midrst_mem_kept", got_d, model_mem[12'h020]);

        // Back-to-back reads held continuously.
        rd_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 12'h010;
        n_acc = 0; rsp_edge = -1; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_v[0] === ready_v[0]) bad++;
            if (ready_v[0] && n_acc < 3) begin
                acc_edge[n_acc] = cyc + 1;
                n_acc++;
            end
            tick();
            if (valid_v[0]) begin
                if (rsp_edge < 0) rsp_edge = cyc;
                if (rdata_v[0] !== 16'hBEEF) bad++;
            end
        end
        rd_v[0] = 1'b0;
        check("b2b_busy_and_data", bad, 0);
        check("b2b_accepts", 32'(n_acc >= 2), 1);
        check("b2b_rsp_seen", 32'(rsp_edge >= 0), 1);
        check("b2b_spacing", acc_edge[1] - acc_edge[0], 4);
        check("b2b_first_rsp", rsp_edge - acc_edge[0], 2);
        check("b2b_second_accept", acc_edge[1] - rsp_edge, 2);
        for (int i = 0; i < 8; i++) tick();

        // RD_LAT=1 instance.
        txn(1, 1'b0, 1'b1, 12'h000, 16'h1357, got_d, got_e, lat);
        check("lat1_wr_latency", lat, exp_lat(1, 1'b0, 1'b1));
        txn(1, 1'b1, 1'b0, 12'h000, 16'h0, got_d, got_e, lat);
        check("lat1_rd_latency", lat, 1);
        check("lat1_rd_data", got_d, 16'h1357);
        txn(1, 1'b1, 1'b1, 12'h000, 16'h2468, got_d, got_e, lat);
        check("lat1_err", got_e, 1);
        check("lat1_err_latency", lat, 1);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            logic [15:0] d;
            logic        rd;
            logic        wr;
            logic [15:0] exp_d;
            int          op;
            a  = pool[$urandom_range(0, 7)];
            d  = 16'($urandom);
            op = $urandom_range(0, 9);
            rd = 1'b0; wr = 1'b0;
            if (op == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else if (op <= 4 || !model_mem.exists(a)) begin
                wr = 1'b1;
            end else begin
                rd = 1'b1;
            end
            exp_d = (rd && !wr) ? model_mem[a] : 16'h0;
            txn(0, rd, wr, a, d, got_d, got_e, lat);
            check($sformatf("rnd%0d_rdata", i), got_d, exp_d);
            check($sformatf("rnd%0d_err", i), got_e, 32'(rd && wr));
            check($sformatf("rnd%0d_latency", i), lat, exp_lat(0, rd, wr));
            if (wr && !rd) model_mem[a] = d;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
